// File: rtl/prog_timer_counter_pkg.sv
// prog_timer_counter_pkg: shared direction, mode and FSM state encodings for the programmable timer/counter
package prog_timer_counter_pkg;
    localparam logic MODE_AUTO    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;
    localparam logic DIR_DN       = 1'b0;
    localparam logic DIR_UP       = 1'b1;
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;
endpackage

// File: rtl/prog_timer_counter_cnt_prescaler.sv
// cnt_prescaler: divides enabled cycles by presc+1 and emits a step strobe
// Ports: clk, reset (sync, active-high), clr (restart phase), run (count this cycle),
//        presc (ratio minus one) -> step_en (strobe in the cycle a counter step is due)
module cnt_prescaler
    import prog_timer_counter_pkg::*;
#(
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               run,
    input  logic [PRESC_W-1:0] presc,
    output logic               step_en
);
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    assign step_en = run && (pcnt_q == presc);
    always_comb begin
        pcnt_d = clr ? '0 : !run ? pcnt_q : step_en ? '0 : pcnt_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) pcnt_q <= '0;
        else       pcnt_q <= pcnt_d;
    end
endmodule

// File: rtl/prog_timer_counter.sv
// prog_timer_counter: prescaled up/down counter with threshold wrap, parallel load and one-shot halt
// Ports: clk, reset (sync, active-high), enable, dn_up (1=up), mode (1=one-shot), load, load_val,
//        cnt_th (threshold, 0 = full range), presc (ratio minus one) -> cntout, timeout (pulse), done (level)
module prog_timer_counter
    import prog_timer_counter_pkg::*;
#(
    parameter int N       = 4,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               dn_up,
    input  logic               mode,
    input  logic               load,
    input  logic [N-1:0]       load_val,
    input  logic [N-1:0]       cnt_th,
    input  logic [PRESC_W-1:0] presc,
    output logic [N-1:0]       cntout,
    output logic               timeout,
    output logic               done
);
    logic [N-1:0] cnt_q, cnt_d, term, nxt;
    logic         tmo_q, tmo_d, done_q, done_d, wrap, up, step_en;
    logic [0:0]   st_q, st_d;
    // cnt_th=0 wraps naturally to 2^N-1, giving the full range
    assign term = cnt_th - 1'b1;
    assign up   = (dn_up == DIR_UP);
    // up uses >= so a threshold lowered below the count still wraps
    assign wrap = up ? (cnt_q >= term) : (cnt_q == '0);
    // down from above a lowered threshold snaps to term without a timeout
    assign nxt  = up ? (wrap ? '0 : cnt_q + 1'b1)
                     : (wrap ? term : (cnt_q > term) ? term : cnt_q - 1'b1);
    cnt_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk    (clk),
        .reset  (reset),
        .clr    (load),
        .run    (enable && st_q == ST_RUN),
        .presc  (presc),
        .step_en(step_en)
    );
    always_comb begin
        cnt_d  = cnt_q;
        tmo_d  = 1'b0;
        done_d = done_q;
        st_d   = st_q;
        if (load) begin
            cnt_d  = load_val;
            done_d = 1'b0;
            st_d   = ST_RUN;
        end else if (step_en) begin
            cnt_d = nxt;
            tmo_d = wrap;
            if (wrap && mode == MODE_ONESHOT) begin
                st_d   = ST_HALT;
                done_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tmo_q  <= 1'b0;
            done_q <= 1'b0;
            st_q   <= ST_RUN;
        end else begin
            cnt_q  <= cnt_d;
            tmo_q  <= tmo_d;
            done_q <= done_d;
            st_q   <= st_d;
        end
    end
    assign cntout  = cnt_q;
    assign timeout = tmo_q;
    assign done    = done_q;
endmodule

// File: tb/tb_prog_timer_counter.sv
// tb_prog_timer_counter: directed self-checking bench for prog_timer_counter
module tb_prog_timer_counter;
    logic       clk = 1'b0;
    logic       reset = 1'b1, enable = 1'b0, dn_up = 1'b1, mode = 1'b0, load = 1'b0;
    logic [3:0] load_val = '0, cnt_th = 4'd5, presc = '0;
    logic [3:0] cntout;
    logic       timeout, done;
    int         n_vec = 0, n_err = 0;

    prog_timer_counter #(.N(4), .PRESC_W(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .dn_up(dn_up), .mode(mode),
        .load(load), .load_val(load_val), .cnt_th(cnt_th), .presc(presc),
        .cntout(cntout), .timeout(timeout), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] c, input logic t, input logic d);
        n_vec++;
        if (cntout !== c || timeout !== t || done !== d) begin
            n_err++;
            $display("FAIL %s: got cnt=%0d tmo=%b done=%b, want cnt=%0d tmo=%b done=%b",
                     name, cntout, timeout, done, c, t, d);
        end
    endtask

    task automatic restart(input logic dir, input logic md, input logic [3:0] th, input logic [3:0] ps);
        reset = 1'b1; load = 1'b0; enable = 1'b1;
        dn_up = dir; mode = md; cnt_th = th; presc = ps;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1;
        tick(); tick();
        chk("reset", 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_up_auto();
        restart(1'b1, 1'b0, 4'd5, 4'd0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk($sformatf("up_auto[%0d]", i), 4'(i % 5), (i % 5) == 0, 1'b0);
        end
    endtask

    task automatic test_down_auto();
        restart(1'b0, 1'b0, 4'd5, 4'd0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk($sformatf("down_auto[%0d]", i), 4'((5 - i % 5) % 5), (i % 5) == 1, 1'b0);
        end
    endtask

    task automatic test_prescale();
        restart(1'b1, 1'b0, 4'd0, 4'd2);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("presc[%0d]", i), 4'(i / 3), 1'b0, 1'b0);
        end
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("presc_hold[%0d]", i), 4'd3, 1'b0, 1'b0);
        end
        enable = 1'b1;
        tick(); chk("presc_resume1", 4'd3, 1'b0, 1'b0);
        tick(); chk("presc_resume2", 4'd4, 1'b0, 1'b0);
        load = 1'b1; load_val = 4'd15;
        tick(); chk("presc_load15", 4'd15, 1'b0, 1'b0);
        load = 1'b0;
        tick(); tick(); chk("presc_pre_wrap", 4'd15, 1'b0, 1'b0);
        tick(); chk("presc_wrap", 4'd0, 1'b1, 1'b0);
        tick(); chk("presc_after_wrap", 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_oneshot();
        restart(1'b1, 1'b1, 4'd3, 4'd0);
        tick(); chk("os1", 4'd1, 1'b0, 1'b0);
        tick(); chk("os2", 4'd2, 1'b0, 1'b0);
        tick(); chk("os_wrap", 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) mode = 1'b0;
            tick();
            chk($sformatf("os_halt[%0d]", i), 4'd0, 1'b0, 1'b1);
        end
        mode = 1'b1; load = 1'b1; load_val = 4'd1;
        tick(); chk("os_load", 4'd1, 1'b0, 1'b0);
        load = 1'b0;
        tick(); chk("os_re2", 4'd2, 1'b0, 1'b0);
        tick(); chk("os_rewrap", 4'd0, 1'b1, 1'b1);
    endtask

    task automatic test_threshold_change();
        restart(1'b1, 1'b0, 4'd9, 4'd0);
        load = 1'b1; load_val = 4'd7;
        tick(); chk("th_load7", 4'd7, 1'b0, 1'b0);
        load = 1'b0; cnt_th = 4'd4;
        tick(); chk("th_up_lowered", 4'd0, 1'b1, 1'b0);
        load = 1'b1; load_val = 4'd9; dn_up = 1'b0;
        tick(); chk("th_load9", 4'd9, 1'b0, 1'b0);
        load = 1'b0;
        tick(); chk("th_dn_snap", 4'd3, 1'b0, 1'b0);
        tick(); chk("th_dn_next", 4'd2, 1'b0, 1'b0);
    endtask

    task automatic test_reset_load();
        restart(1'b1, 1'b0, 4'd0, 4'd0);
        tick(); tick(); tick();
        chk("rl_running", 4'd3, 1'b0, 1'b0);
        reset = 1'b1; load = 1'b1; load_val = 4'd9;
        tick(); chk("rl_reset_wins", 4'd0, 1'b0, 1'b0);
        reset = 1'b0; load = 1'b0;
        tick(); chk("rl_count1", 4'd1, 1'b0, 1'b0);
        reset = 1'b1; #3; reset = 1'b0;
        tick(); chk("rl_glitch", 4'd2, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_up_auto();
        test_down_auto();
        test_prescale();
        test_oneshot();
        test_threshold_change();
        test_reset_load();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
